wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//  Writeback-side producer for the integer register file write port (we/addr/wdata).
//  Merges results from ALU and LSU into a small in-order queue and drains one write per cycle.
//  Answers two decode-stage lookups, forwarding the newest queued value for a register.
//  Sits between the execute/memory stages and the register file, which writes on negedge clk.
// PARAMETERS
//  XLEN   32  data width of a register value
//  AW     5   register address width (2**AW architectural registers)
//  DEPTH  4   queue entries; power of two, >= 2
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  reset        in   1     reset, asynchronous, active-high
//  alu_valid    in   1     ALU result present
//  alu_rd       in   AW    ALU destination register
//  alu_data     in   XLEN  ALU result
//  alu_ready    out  1     queue accepts ALU result this cycle
//  lsu_valid    in   1     load result present
//  lsu_rd       in   AW    load destination register
//  lsu_data     in   XLEN  load result
//  lsu_ready    out  1     queue accepts LSU result this cycle
//  rf_we        out  1     register file write enable
//  rf_addr      out  AW    register file write address
//  rf_wdata     out  XLEN  register file write data
//  rs1_addr     in   AW    decode lookup address 1
//  rs1_hit      out  1     a queued entry targets rs1_addr
//  rs1_data     out  XLEN  value from newest matching entry; 0 when no hit
//  rs2_addr     in   AW    decode lookup address 2
//  rs2_hit      out  1     as rs1_hit for rs2_addr
//  rs2_data     out  XLEN  as rs1_data for rs2_addr
//  count        out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset (async): wr/rd pointers and count go to 0, all entries invalid. Outputs: rf_we=0,
//    rf_addr=0, rf_wdata=0, rs*_hit=0, rs*_data=0, count=0. Readies go to 1 (DEPTH >= 2).
//    Reset mid-operation discards queued writes. No write reaches the register file during reset.
//  - A transfer happens when valid&&ready at posedge. Ready depends only on registered count,
//    never on valid. Let free = DEPTH - count:
//    - free >= 2: both readies are 1.
//    - free == 1: lsu_ready=1 and alu_ready=0. LSU has priority.
//    - free == 0: both readies are 0.
//  - Simultaneous accept: the LSU entry is enqueued first (older), then the ALU entry (two slots).
//  - rd == 0: the result is accepted (handshake completes) but not enqueued; it consumes no slot.
//  - Drain: rf_we = (count != 0). rf_addr and rf_wdata are the head entry, driven combinationally
//    from registered state. rf_addr and rf_wdata are 0 when empty. The register file always accepts,
//    so the head pops at every posedge with count != 0.
//  - Latency: a result accepted at posedge N drives rf_we during cycle N+1 if the queue was empty.
//    The register file captures it at the negedge of cycle N+1, and the entry pops at posedge N+1.
//  - count_next = count + enq_count - pop. Enqueue and pop occur in the same edge.
//    Pointers wrap modulo DEPTH. Full and empty are derived from count, not from the pointers.
//  - Lookup (combinational): compare rsX_addr against all valid entries, including the head.
//    The newest (closest to the tail) match wins. rsX_addr == 0 never hits.
//    Results being offered this cycle but not yet enqueued are not visible to lookup.
//  - Program order is preserved: for the same rd, writes drain in enqueue order.
// STRUCTURE
//  - Shared package cpu_pkg: XLEN, REG_AW, typedef wb_entry_t {logic [AW-1:0] rd; logic [XLEN-1:0] data;}.
//  - Sub-module wb_fwd_match: DEPTH-way newest-match priority selector.
//    Instantiated twice (rs1, rs2); takes entry array, valid mask, head pointer and address.
//  - Storage: wb_entry_t array plus valid bits, in the top module.
// TESTING
//  1. Assert reset with the queue holding 3 entries -> rf_we=0, count=0, both ready=1, rs1_hit=0
//     in the same cycle.
//  2. alu_valid, rd=5, data=32'hDEAD_BEEF at edge N (empty queue) -> cycle N+1: rf_we=1,
//     rf_addr=5, rf_wdata=32'hDEAD_BEEF. Cycle N+2: rf_we=0.
//  3. Same edge: lsu (rd=3, 32'h11) and alu (rd=4, 32'h22) -> rf writes r3=32'h11 then r4=32'h22
//     on consecutive cycles. count goes 2, 1, 0.
//  4. Hold both valid for 4 cycles, DEPTH=4 -> count reaches 3 with alu_ready=0 and lsu_ready=1.
//     Every accepted value drains in order. Nothing is lost or duplicated.
//  5. alu_valid with rd=0 -> alu accepted, count unchanged, rf_we stays 0.
//  6. Queue r7=32'hA then r7=32'hB, rs1_addr=7 -> rs1_hit=1 and rs1_data=32'hB.
//     After both drain, rs1_hit=0.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// wb_write_queue_pkg: register-file widths and the queued writeback entry type.
package wb_write_queue_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: ALU/LSU result handshakes, register-file write port and decode lookups.
interface wb_write_queue_if #(parameter int DEPTH = 4);
  import wb_write_queue_pkg::*;
  logic                       alu_valid;
  logic [REG_AW-1:0]          alu_rd;
  logic [XLEN-1:0]            alu_data;
  logic                       alu_ready;
  logic                       lsu_valid;
  logic [REG_AW-1:0]          lsu_rd;
  logic [XLEN-1:0]            lsu_data;
  logic                       lsu_ready;
  logic                       rf_we;
  logic [REG_AW-1:0]          rf_addr;
  logic [XLEN-1:0]            rf_wdata;
  logic [REG_AW-1:0]          rs1_addr;
  logic                       rs1_hit;
  logic [XLEN-1:0]            rs1_data;
  logic [REG_AW-1:0]          rs2_addr;
  logic                       rs2_hit;
  logic [XLEN-1:0]            rs2_data;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, rf_we, rf_addr, rf_wdata, rs1_hit, rs1_data, rs2_hit, rs2_data, count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, rf_we, rf_addr, rf_wdata, rs1_hit, rs1_data, rs2_hit, rs2_data, count
  );
endinterface

// File: rtl/wb_write_queue_fwd_match.sv
// wb_fwd_match: picks the newest valid queue entry whose rd matches addr (r0 never matches).
module wb_fwd_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] ent,
  input  logic [DEPTH-1:0]      vld,
  input  logic [PW-1:0]         head,
  input  logic [REG_AW-1:0]     addr,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);
  // Walk oldest to newest from the head so later matches override earlier ones.
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr != '0 && vld[head + PW'(i)] && ent[head + PW'(i)].rd == addr) begin
        hit = 1'b1;
        data = ent[head + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order ALU/LSU writeback queue draining one register-file write per cycle.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  wb_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] wr_ptr, rd_ptr, alu_slot;
  logic [CW-1:0] cnt;
  logic lsu_enq, alu_enq, pop;
  // Readies come from registered count only; the LSU keeps the last free slot.
  assign bus.lsu_ready = cnt != CW'(DEPTH);
  assign bus.alu_ready = cnt < CW'(DEPTH-1);
  assign lsu_enq = bus.lsu_valid && bus.lsu_ready && bus.lsu_rd != '0;
  assign alu_enq = bus.alu_valid && bus.alu_ready && bus.alu_rd != '0;
  assign pop = cnt != '0;
  assign alu_slot = wr_ptr + PW'(lsu_enq);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      wr_ptr <= alu_slot + PW'(alu_enq);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt <= cnt + CW'(lsu_enq) + CW'(alu_enq) - CW'(pop);
      vld <= (vld & ~(DEPTH'(pop) << rd_ptr)) | (DEPTH'(lsu_enq) << wr_ptr) | (DEPTH'(alu_enq) << alu_slot);
    end
  end
  always_ff @(posedge clk) begin
    if (lsu_enq) ent[wr_ptr] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
    if (alu_enq) ent[alu_slot] <= '{rd: bus.alu_rd, data: bus.alu_data};
  end
  assign bus.rf_we = pop;
  assign bus.rf_addr = pop ? ent[rd_ptr].rd : '0;
  assign bus.rf_wdata = pop ? ent[rd_ptr].data : '0;
  assign bus.count = cnt;
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .ent(ent), .vld(vld), .head(rd_ptr), .addr(bus.rs1_addr), .hit(bus.rs1_hit), .data(bus.rs1_data)
  );
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .ent(ent), .vld(vld), .head(rd_ptr), .addr(bus.rs2_addr), .hit(bus.rs2_hit), .data(bus.rs2_data)
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: random and directed ALU/LSU traffic scored against a queue-of-writes model.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nvec = 0;
  int nerr = 0;
  wb_entry_t exp_q[$];
  bit st_lr = 1'b1;
  bit st_ar = 1'b1;
  int n;
  logic [32:0] lk;

  wb_write_queue_if #(.DEPTH(DEPTH)) bus();
  wb_write_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Newest pending write to a nonzero register, as {hit, data}.
  function automatic logic [32:0] lookup(logic [REG_AW-1:0] a);
    logic [32:0] r = '0;
    foreach (exp_q[i]) if (a != '0 && exp_q[i].rd == a) r = {1'b1, exp_q[i].data};
    return r;
  endfunction

  // Monitor: compares every mid-cycle output against the model and retires the head write.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_rf_we", bus.rf_we, 0);
      chk("reset_count", bus.count, 0);
      st_lr = 1'b1;
      st_ar = 1'b1;
    end else begin
      n = exp_q.size();
      chk("count", bus.count, n);
      chk("lsu_ready", bus.lsu_ready, n < DEPTH);
      chk("alu_ready", bus.alu_ready, n <= DEPTH-2);
      st_lr = n < DEPTH;
      st_ar = n <= DEPTH-2;
      lk = lookup(bus.rs1_addr);
      chk("rs1_hit", bus.rs1_hit, lk[32]);
      chk("rs1_data", bus.rs1_data, lk[31:0]);
      lk = lookup(bus.rs2_addr);
      chk("rs2_hit", bus.rs2_hit, lk[32]);
      chk("rs2_data", bus.rs2_data, lk[31:0]);
      chk("rf_we", bus.rf_we, n != 0);
      if (n != 0) begin
        chk("rf_addr", bus.rf_addr, exp_q[0].rd);
        chk("rf_wdata", bus.rf_wdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("rf_addr_idle", bus.rf_addr, 0);
        chk("rf_wdata_idle", bus.rf_wdata, 0);
      end
    end
  end

  // Drive one cycle of offers, then record what the model says was enqueued at the edge.
  task automatic step(bit lv, logic [4:0] lrd, logic [31:0] ld, bit av, logic [4:0] ard, logic [31:0] ad,
                      logic [4:0] r1, logic [4:0] r2);
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.rs1_addr = r1; bus.rs2_addr = r2;
    @(posedge clk);
    #1;
    if (lv && st_lr && lrd != 0) exp_q.push_back('{rd: lrd, data: ld});
    if (av && st_ar && ard != 0) exp_q.push_back('{rd: ard, data: ad});
  endtask

  task automatic idle(int k, logic [4:0] r1);
    repeat (k) step(0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  initial begin
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 5, 0);
    idle(3, 5);
    step(1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
    idle(3, 4);
    repeat (4) step(1, 5'($urandom_range(1, 7)), $urandom, 1, 5'($urandom_range(1, 7)), $urandom, 1, 2);
    idle(5, 0);
    step(0, 0, 0, 1, 0, 32'h99, 0, 0);
    idle(2, 0);
    step(1, 7, 32'hA, 1, 7, 32'hB, 7, 0);
    idle(3, 7);
    step(1, 3, 32'h33, 1, 6, 32'h66, 3, 6);
    step(1, 2, 32'h44, 1, 1, 32'h55, 3, 6);
    #1 reset = 1'b1;
    #1;
    chk("async_rf_we", bus.rf_we, 0);
    chk("async_count", bus.count, 0);
    chk("async_lsu_ready", bus.lsu_ready, 1);
    chk("async_alu_ready", bus.alu_ready, 1);
    chk("async_rs1_hit", bus.rs1_hit, 0);
    exp_q.delete();
    bus.lsu_valid = 0;
    bus.alu_valid = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2, 3);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(DEPTH + 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
